// File: rtl/carrier_safety_ramp.sv
// AM carrier amplitude gate driven by the watchdog: ramps the carrier up and down
// in fixed steps, and latches a fault on watchdog expiry until it is explicitly cleared.
module carrier_safety_ramp #(
  parameter int AMP_W      = 16,
  parameter int STEP       = 256,
  parameter int DIV        = 4,
  parameter int WARN_SHIFT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_en,
  input  logic [AMP_W-1:0] amp_in,
  input  logic             wd_warning,
  input  logic             wd_triggered,
  input  logic             fault_clear,
  output logic [AMP_W-1:0] amp_out,
  output logic             rf_enable,
  output logic             fault_latched,
  output logic [2:0]       state_o
);

  typedef enum logic [2:0] {
    S_OFF       = 3'd0,
    S_RAMP_UP   = 3'd1,
    S_ON        = 3'd2,
    S_RAMP_DOWN = 3'd3,
    S_FAULT     = 3'd4
  } state_t;

  localparam int             CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(DIV - 1);
  localparam logic [AMP_W:0] STEP_X  = (AMP_W + 1)'(STEP);

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [AMP_W-1:0] target, amp_nxt;
  logic [AMP_W:0]   amp_x, sum_up;
  logic             tick, abort, flt_nxt;

  always_comb begin
    target    = wd_warning ? (amp_in >> WARN_SHIFT) : amp_in;
    tick      = (cnt == CNT_MAX);
    abort     = wd_triggered | ~tx_en;
    // one extra bit so the upward step saturates at target instead of wrapping
    amp_x     = {1'b0, amp_out};
    sum_up    = amp_x + STEP_X;
    state_nxt = state;
    amp_nxt   = amp_out;
    case (state)
      S_OFF: begin
        amp_nxt = '0;
        if (wd_triggered || fault_latched) state_nxt = S_FAULT;
        else if (tx_en)                    state_nxt = S_RAMP_UP;
      end
      S_RAMP_UP: begin
        if (abort)                  state_nxt = S_RAMP_DOWN;
        else if (amp_out >= target) state_nxt = S_ON;
        else if (tick)
          amp_nxt = (sum_up >= {1'b0, target}) ? target : sum_up[AMP_W-1:0];
      end
      S_ON: begin
        // amplitude is held on the way out so the ramp down starts from where we were
        if (abort) state_nxt = S_RAMP_DOWN;
        else       amp_nxt   = target;
      end
      S_RAMP_DOWN: begin
        if (amp_out == '0)
          state_nxt = (fault_latched || wd_triggered) ? S_FAULT : S_OFF;
        else if (tick)
          amp_nxt = (amp_x > STEP_X) ? AMP_W'(amp_x - STEP_X) : '0;
      end
      S_FAULT: begin
        amp_nxt = '0;
        if (fault_clear && !wd_triggered) state_nxt = S_OFF;
      end
      default: begin
        state_nxt = S_OFF;
        amp_nxt   = '0;
      end
    endcase
    // a new trigger beats a clear arriving in the same cycle
    flt_nxt = wd_triggered | (fault_latched & ~((state == S_FAULT) & fault_clear));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_OFF;
      amp_out       <= '0;
      rf_enable     <= 1'b0;
      fault_latched <= 1'b0;
      cnt           <= '0;
    end else begin
      state         <= state_nxt;
      amp_out       <= amp_nxt;
      rf_enable     <= (state_nxt == S_RAMP_UP) || (state_nxt == S_ON) ||
                       (state_nxt == S_RAMP_DOWN);
      fault_latched <= flt_nxt;
      cnt           <= ((state_nxt != state) || tick) ? '0 : cnt + 1'b1;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_carrier_safety_ramp.sv
// Bench for carrier_safety_ramp: directed scenarios with literal checks, then random
// stimulus, all compared every cycle against a cycle-age based behavioural model.
module tb_carrier_safety_ramp;

  localparam int AMP_W = 16, STEP = 256, DIV = 4, WARN_SHIFT = 1;
  localparam int OFF = 0, UP = 1, ON = 2, DOWN = 3, FLT = 4;

  logic             clk, rst, tx_en, wd_warning, wd_triggered, fault_clear;
  logic [AMP_W-1:0] amp_in, amp_out;
  logic             rf_enable, fault_latched;
  logic [2:0]       state_o;

  carrier_safety_ramp #(.AMP_W(AMP_W), .STEP(STEP), .DIV(DIV), .WARN_SHIFT(WARN_SHIFT)) dut (
    .clk(clk), .rst(rst), .tx_en(tx_en), .amp_in(amp_in), .wd_warning(wd_warning),
    .wd_triggered(wd_triggered), .fault_clear(fault_clear), .amp_out(amp_out),
    .rf_enable(rf_enable), .fault_latched(fault_latched), .state_o(state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Model: age = cycles spent in the current state; a ramp step lands every DIV-th cycle.
  int m_st = OFF, m_amp = 0, m_rf = 0, m_flt = 0, m_age = 0;

  always @(posedge clk) begin
    int tgt, nst, namp;
    bit tick;
    if (rst) begin
      m_st = OFF; m_amp = 0; m_rf = 0; m_flt = 0; m_age = 0;
    end else begin
      tgt  = wd_warning ? (int'(amp_in) >> WARN_SHIFT) : int'(amp_in);
      tick = (m_age % DIV) == DIV - 1;
      nst  = m_st;
      namp = m_amp;
      if (m_st == OFF) begin
        namp = 0;
        if (wd_triggered || m_flt != 0) nst = FLT;
        else if (tx_en) nst = UP;
      end else if (m_st == UP) begin
        if (wd_triggered || !tx_en) nst = DOWN;
        else if (m_amp >= tgt) nst = ON;
        else if (tick) namp = (m_amp + STEP < tgt) ? m_amp + STEP : tgt;
      end else if (m_st == ON) begin
        if (wd_triggered || !tx_en) nst = DOWN;
        else namp = tgt;
      end else if (m_st == DOWN) begin
        if (m_amp == 0) nst = (m_flt != 0 || wd_triggered) ? FLT : OFF;
        else if (tick) namp = (m_amp - STEP > 0) ? m_amp - STEP : 0;
      end else begin
        namp = 0;
        if (fault_clear && !wd_triggered) nst = OFF;
      end
      if (wd_triggered) m_flt = 1;
      else if (m_st == FLT && fault_clear) m_flt = 0;
      m_age = (nst != m_st) ? 0 : m_age + 1;
      m_st  = nst;
      m_amp = namp;
      m_rf  = (nst == UP || nst == ON || nst == DOWN) ? 1 : 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_amp",   int'(amp_out),       m_amp);
      check("model_state", int'(state_o),       m_st);
      check("model_rf",    int'(rf_enable),     m_rf);
      check("model_fault", int'(fault_latched), m_flt);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; tx_en = 1'b0; amp_in = '0;
    wd_warning = 1'b0; wd_triggered = 1'b0; fault_clear = 1'b0;
    cyc(2);
    chk_en = 1'b1;
    check("reset_state", int'(state_o), OFF);
    check("reset_amp", int'(amp_out), 0);
    check("reset_rf", int'(rf_enable), 0);
    check("reset_fault", int'(fault_latched), 0);

    // ramp up to 0x1000
    rst = 1'b0; tx_en = 1'b1; amp_in = 16'h1000;
    cyc(1);
    check("up_entry_state", int'(state_o), UP);
    check("up_entry_rf", int'(rf_enable), 1);
    cyc(4);  check("up_first_step", int'(amp_out), 16'h0100);
    cyc(60); check("up_top_amp", int'(amp_out), 16'h1000);
    cyc(1);  check("up_to_on", int'(state_o), ON);

    // normal ramp down
    tx_en = 1'b0;
    cyc(1);  check("down_entry", int'(state_o), DOWN);
    cyc(4);  check("down_first_step", int'(amp_out), 16'h0F00);
    cyc(60); check("down_zero", int'(amp_out), 0);
    cyc(1);
    check("down_off_state", int'(state_o), OFF);
    check("down_off_rf", int'(rf_enable), 0);

    // watchdog expiry while ON
    tx_en = 1'b1;
    cyc(66); check("reon_state", int'(state_o), ON);
    wd_triggered = 1'b1;
    cyc(1);
    wd_triggered = 1'b0;
    check("trig_state", int'(state_o), DOWN);
    check("trig_fault", int'(fault_latched), 1);
    cyc(4);  check("trig_step", int'(amp_out), 16'h0F00);
    cyc(60); check("trig_zero", int'(amp_out), 0);
    cyc(1);  check("trig_fault_state", int'(state_o), FLT);
    cyc(3);  check("fault_holds_tx", int'(state_o), FLT);

    // clear, then clear racing a new trigger
    fault_clear = 1'b1;
    cyc(1);
    fault_clear = 1'b0;
    check("clear_off", int'(state_o), OFF);
    check("clear_flag", int'(fault_latched), 0);
    cyc(1);  check("clear_reup", int'(state_o), UP);
    wd_triggered = 1'b1;
    cyc(1);  wd_triggered = 1'b0;
    check("up_abort", int'(state_o), DOWN);
    cyc(1);  check("up_abort_fault", int'(state_o), FLT);
    fault_clear = 1'b1; wd_triggered = 1'b1;
    cyc(1);  wd_triggered = 1'b0;
    check("clear_vs_trig_state", int'(state_o), FLT);
    check("clear_vs_trig_flag", int'(fault_latched), 1);
    cyc(1);  fault_clear = 1'b0;
    check("clear2_off", int'(state_o), OFF);

    // warning halves target in ON
    cyc(66); check("warn_pre", int'(amp_out), 16'h1000);
    wd_warning = 1'b1;
    cyc(1);  check("warn_half", int'(amp_out), 16'h0800);
    wd_warning = 1'b0;
    cyc(1);  check("warn_restore", int'(amp_out), 16'h1000);

    // saturating ramp near full scale
    rst = 1'b1;
    cyc(1);  rst = 1'b0; amp_in = 16'hFFF0;
    cyc(1);  check("sat_entry", int'(state_o), UP);
    cyc(1020); check("sat_last_full_step", int'(amp_out), 16'hFF00);
    cyc(4);  check("sat_top", int'(amp_out), 16'hFFF0);
    cyc(1);  check("sat_on", int'(state_o), ON);

    // reset mid-ramp
    rst = 1'b1;
    cyc(1);  rst = 1'b0; amp_in = 16'h1000;
    cyc(1);
    cyc(8);  check("mid_amp", int'(amp_out), 16'h0200);
    rst = 1'b1;
    cyc(1);  rst = 1'b0;
    check("abort_state", int'(state_o), OFF);
    check("abort_amp", int'(amp_out), 0);
    check("abort_rf", int'(rf_enable), 0);

    // zero target passes straight through to ON
    amp_in = '0;
    cyc(1);  check("zero_up", int'(state_o), UP);
    cyc(1);
    check("zero_on", int'(state_o), ON);
    check("zero_rf", int'(rf_enable), 1);

    // random phase
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 39) == 0) tx_en = ~tx_en;
      if ($urandom_range(0, 63) == 0) begin
        case ($urandom_range(0, 3))
          0: amp_in = '0;
          1: amp_in = 16'($urandom_range(0, 16'h0400));
          2: amp_in = 16'($urandom_range(16'hFE00, 16'hFFFF));
          default: amp_in = 16'($urandom_range(0, 16'hFFFF));
        endcase
      end
      if ($urandom_range(0, 49) == 0) wd_warning = ~wd_warning;
      wd_triggered = ($urandom_range(0, 399) == 0);
      fault_clear  = ($urandom_range(0, 29) == 0);
      rst          = ($urandom_range(0, 999) == 0);
      cyc(1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/carrier_safety_ramp.md
Name: carrier_safety_ramp

Overview:
Sits directly downstream of watchdog_timer. It consumes the watchdog's triggered/warning outputs and gates the AM carrier amplitude sent to the modulator DAC path. Enable and disable requests, and watchdog expiry, never step the carrier abruptly: the amplitude ramps to its target or to zero. A watchdog expiry latches a fault that only an explicit clear can release.

Parameters:
AMP_W, 16, amplitude word width (unsigned)
STEP, 256, amplitude change per ramp tick
DIV, 4, clock cycles per ramp tick (DIV >= 1)
WARN_SHIFT, 1, right-shift applied to amp_in while wd_warning=1

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
tx_en  in  1  host request to transmit (level)
amp_in  in  AMP_W  requested carrier amplitude
wd_warning  in  1  watchdog warning level
wd_triggered  in  1  watchdog expired level
fault_clear  in  1  single-cycle fault release strobe
amp_out  out  AMP_W  registered amplitude to modulator
rf_enable  out  1  registered RF output enable
fault_latched  out  1  sticky watchdog fault flag
state_o  out  3  current state encoding: OFF=0, RAMP_UP=1, ON=2, RAMP_DOWN=3, FAULT=4

Behaviour:
- Reset (rst=1 at posedge):
  - state=OFF, amp_out=0, rf_enable=0, fault_latched=0, tick counter=0.
  - Reset overrides every other input, including mid-ramp.
- target = wd_warning ? (amp_in >> WARN_SHIFT) : amp_in. Evaluated every cycle.
- Tick counter:
  - Counts 0..DIV-1 and resets to 0 on every state change.
  - A tick occurs in the cycle the counter equals DIV-1.
  - The first step after entering a ramp state lands DIV cycles after entry.
- fault_latched:
  - Set in any cycle where wd_triggered=1.
  - Cleared only in FAULT when fault_clear=1 and wd_triggered=0.
  - If set and clear occur in the same cycle, set wins.
- OFF: amp_out=0, rf_enable=0.
  - wd_triggered=1 or fault_latched=1 -> FAULT.
  - Else tx_en=1 -> RAMP_UP; rf_enable=1 from that cycle's edge.
- RAMP_UP: rf_enable=1.
  - wd_triggered=1 or tx_en=0 -> RAMP_DOWN. This check has priority.
  - On a tick: amp_out = min(amp_out+STEP, target). Compute the sum at AMP_W+1 bits; it saturates and never wraps.
  - If amp_out >= target at any cycle -> ON.
- ON: amp_out <= target every cycle (1-cycle latency). Upward changes are not ramped.
  - wd_triggered=1 or tx_en=0 -> RAMP_DOWN.
- RAMP_DOWN: rf_enable=1.
  - On a tick: amp_out = amp_out>STEP ? amp_out-STEP : 0. Floors at 0 and never wraps.
  - When amp_out==0 (including on entry) -> FAULT if fault_latched or wd_triggered, else OFF.
  - rf_enable=0 from that transition.
  - tx_en reasserting during RAMP_DOWN is ignored until OFF is reached.
- FAULT: amp_out=0, rf_enable=0.
  - fault_clear=1 and wd_triggered=0 -> OFF, with fault_latched cleared.
  - tx_en is ignored in FAULT. Leaving FAULT needs a fresh tx_en in OFF (tx_en held high re-enters RAMP_UP one cycle later).
- Simultaneous events:
  - wd_triggered together with tx_en rising in OFF -> FAULT directly; no ramp.
  - wd_warning asserting in ON halves amp_out on the next cycle.
  - wd_warning in RAMP_UP lowers the target immediately. If amp_out >= the new target -> ON, which applies the lower value the following cycle.
- The zero-target edge: amp_in=0 with tx_en=1 goes OFF -> RAMP_UP -> ON immediately (amp_out>=target). rf_enable=1, amp_out=0.
- No combinational path from inputs to outputs.

Test Plan:
1. Reset, then tx_en=1, amp_in=0x1000, wd_*=0. Expect state RAMP_UP and rf_enable=1 after 1 cycle. amp_out steps 0x100 every 4 cycles, reaches 0x1000 at 64 cycles after entry, then state=ON.
2. In ON at 0x1000, drop tx_en. Expect RAMP_DOWN, amp_out 0x0F00 after 4 cycles and 0 after 64. Then state=OFF, rf_enable=0, fault_latched=0.
3. In ON at 0x1000, pulse wd_triggered for 1 cycle. Expect fault_latched=1 next cycle and a ramp to 0 over 64 cycles, then FAULT. tx_en held high keeps amp_out=0.
4. In FAULT, pulse fault_clear with wd_triggered=0 and tx_en=1. Expect OFF with fault_latched=0, then RAMP_UP on the next cycle. Repeat with wd_triggered=1 on the same cycle as the clear: stays FAULT.
5. In ON at 0x1000, assert wd_warning. Expect amp_out=0x0800 one cycle later. Deassert it: amp_out=0x1000 one cycle later.
6. Saturation and abort: amp_in=0xFFF0, STEP=256. Expect the ramp to end at exactly 0xFFF0, not wrapped. Separately, assert rst mid RAMP_UP: next cycle amp_out=0, rf_enable=0, state=OFF.
